// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and lamp constants for the traffic controller
//
// Purpose: phase state encoding, lamp patterns and lamp bit positions used by
//          traffic_ctrl_param and anyone decoding its lights output.
// Ports:   none (package).

package traffic_pkg;

   typedef enum logic [2:0] {
      S_EW_GREEN  = 3'd0,
      S_EW_YELLOW = 3'd1,
      S_ALLRED1   = 3'd2,
      S_NS_GREEN  = 3'd3,
      S_NS_YELLOW = 3'd4,
      S_ALLRED2   = 3'd5,
      S_WALK      = 3'd6,
      S_FLASH     = 3'd7
   } state_e;

   // lights = {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G}
   localparam int LI_NS_R = 5;
   localparam int LI_NS_Y = 4;
   localparam int LI_NS_G = 3;
   localparam int LI_EW_R = 2;
   localparam int LI_EW_Y = 1;
   localparam int LI_EW_G = 0;

   localparam logic [5:0] L_EW_G     = 6'b100001;
   localparam logic [5:0] L_EW_Y     = 6'b100010;
   localparam logic [5:0] L_ALLRED   = 6'b100100;
   localparam logic [5:0] L_NS_G     = 6'b001100;
   localparam logic [5:0] L_NS_Y     = 6'b010100;
   localparam logic [5:0] L_FLASH_ON = 6'b010100;
   localparam logic [5:0] L_DARK     = 6'b000000;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-gated phase counter with end-of-phase strobe
//
// Purpose: counts ticks within the current phase and flags the last tick.
// Ports:   clk     - system clock, rising edge
//          clr     - synchronous active-high reset, cnt := 0
//          tick_en - advance enable; cnt holds while low
//          load    - restart the phase (cnt := 0 on this edge)
//          T       - current phase length in ticks (>= 1)
//          done    - high on the tick where cnt == T-1

module phase_timer #(
   parameter int CNT_W = 26
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             tick_en,
   input  logic             load,
   input  logic [CNT_W-1:0] T,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (tick_en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = tick_en && (cnt_q == (T - CNT_W'(1)));

endmodule

// File: rtl/traffic_ctrl_param.sv
// rtl/traffic_ctrl_param.sv - parametrised NS/EW traffic controller with walk and night flash
//
// Purpose: six-phase light sequencer with a latched pedestrian request served
//          from the all-red phases and a night flashing mode.
// Ports:   clk         - system clock, rising edge
//          clr         - synchronous active-high reset
//          tick_en     - counter advance enable from the shared prescaler
//          ped_req     - pedestrian request (level or pulse)
//          night       - night flashing mode request
//          lights      - {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G}
//          walk        - pedestrian walk lamp
//          ped_pending - request latched and not yet served

module traffic_ctrl_param
   import traffic_pkg::*;
#(
   parameter int CNT_W    = 26,
   parameter int T_GREEN  = 33333333,
   parameter int T_YELLOW = 22222222,
   parameter int T_ALLRED = 22222222,
   parameter int T_WALK   = 33333333,
   parameter int T_FLASH  = 12500000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       tick_en,
   input  logic       ped_req,
   input  logic       night,
   output logic [5:0] lights,
   output logic       walk,
   output logic       ped_pending
);

   localparam longint T_MAX = (longint'(1) << CNT_W) - longint'(1);

   generate
      if (T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1 || T_WALK < 1 || T_FLASH < 1) begin : g_t_min
         $error("traffic_ctrl_param: every T_* must be at least 1");
      end
      if (longint'(T_GREEN) > T_MAX || longint'(T_YELLOW) > T_MAX || longint'(T_ALLRED) > T_MAX ||
          longint'(T_WALK) > T_MAX || longint'(T_FLASH) > T_MAX) begin : g_t_max
         $error("traffic_ctrl_param: a T_* value does not fit in CNT_W bits");
      end
   endgenerate

   state_e           state_q, state_d;
   logic             ped_pending_q, ped_pending_d;
   logic             flash_ph_q, flash_ph_d;
   logic             ret_ns_q, ret_ns_d;
   logic             load;
   logic             done;
   logic             enter_walk;
   logic [CNT_W-1:0] phase_len;

   always_comb begin
      phase_len = CNT_W'(T_GREEN);
      case (state_q)
         S_EW_GREEN, S_NS_GREEN:  phase_len = CNT_W'(T_GREEN);
         S_EW_YELLOW, S_NS_YELLOW: phase_len = CNT_W'(T_YELLOW);
         S_ALLRED1, S_ALLRED2:    phase_len = CNT_W'(T_ALLRED);
         S_WALK:                  phase_len = CNT_W'(T_WALK);
         S_FLASH:                 phase_len = CNT_W'(T_FLASH);
         default:                 phase_len = CNT_W'(T_GREEN);
      endcase
   end

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .clr     (clr),
      .tick_en (tick_en),
      .load    (load),
      .T       (phase_len),
      .done    (done)
   );

   // Next-state logic. load restarts the counter whenever the phase (or the
   // flash half-period) ends.
   always_comb begin
      state_d    = state_q;
      flash_ph_d = flash_ph_q;
      ret_ns_d   = ret_ns_q;
      load       = 1'b0;
      enter_walk = 1'b0;
      case (state_q)
         S_EW_GREEN:  if (done) begin state_d = S_EW_YELLOW; load = 1'b1; end
         S_EW_YELLOW: if (done) begin state_d = S_ALLRED1;   load = 1'b1; end
         S_NS_GREEN:  if (done) begin state_d = S_NS_YELLOW; load = 1'b1; end
         S_NS_YELLOW: if (done) begin state_d = S_ALLRED2;   load = 1'b1; end
         S_ALLRED1, S_ALLRED2: begin
            if (done) begin
               load = 1'b1;
               if (night) begin
                  state_d = S_FLASH;
               end else if (ped_pending_q) begin
                  state_d    = S_WALK;
                  enter_walk = 1'b1;
                  ret_ns_d   = (state_q == S_ALLRED1);
               end else begin
                  state_d = (state_q == S_ALLRED1) ? S_NS_GREEN : S_EW_GREEN;
               end
            end
         end
         S_WALK: begin
            if (done) begin
               state_d = ret_ns_q ? S_NS_GREEN : S_EW_GREEN;
               load    = 1'b1;
            end
         end
         S_FLASH: begin
            // Leaving night mode is checked on every tick and wins over the
            // half-period toggle; clearance always restarts from lamp-on phase.
            if (tick_en && !night) begin
               state_d    = S_ALLRED2;
               flash_ph_d = 1'b1;
               load       = 1'b1;
            end else if (done) begin
               flash_ph_d = ~flash_ph_q;
               load       = 1'b1;
            end
         end
         default: begin
            state_d = S_EW_GREEN;
            load    = 1'b1;
         end
      endcase
   end

   // A new request on the WALK entry edge survives the clear.
   assign ped_pending_d = ped_req | (ped_pending_q & ~enter_walk);

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q       <= S_EW_GREEN;
         ped_pending_q <= 1'b0;
         flash_ph_q    <= 1'b1;
         ret_ns_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ped_pending_q <= ped_pending_d;
         flash_ph_q    <= flash_ph_d;
         ret_ns_q      <= ret_ns_d;
      end
   end

   always_comb begin
      lights = L_ALLRED;
      walk   = 1'b0;
      case (state_q)
         S_EW_GREEN:  lights = L_EW_G;
         S_EW_YELLOW: lights = L_EW_Y;
         S_ALLRED1:   lights = L_ALLRED;
         S_NS_GREEN:  lights = L_NS_G;
         S_NS_YELLOW: lights = L_NS_Y;
         S_ALLRED2:   lights = L_ALLRED;
         S_WALK: begin
            lights = L_ALLRED;
            walk   = 1'b1;
         end
         S_FLASH:     lights = flash_ph_q ? L_FLASH_ON : L_DARK;
         default:     lights = L_ALLRED;
      endcase
   end

   assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// tb/tb_traffic_ctrl_param.sv - scoreboard bench for traffic_ctrl_param

module tb_traffic_ctrl_param;

   localparam logic [5:0] EWG = 6'b100001;
   localparam logic [5:0] EWY = 6'b100010;
   localparam logic [5:0] AR  = 6'b100100;
   localparam logic [5:0] NSG = 6'b001100;
   localparam logic [5:0] NSY = 6'b010100;
   localparam logic [5:0] FON = 6'b010100;
   localparam logic [5:0] DRK = 6'b000000;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       tick_en = 1'b1;
   logic       ped_req = 1'b0;
   logic       night = 1'b0;
   logic [5:0] lights;
   logic       walk;
   logic       ped_pending;

   typedef struct {
      logic [5:0] l;
      logic       w;
      logic       p;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   traffic_ctrl_param #(
      .CNT_W    (4),
      .T_GREEN  (5),
      .T_YELLOW (2),
      .T_ALLRED (1),
      .T_WALK   (3),
      .T_FLASH  (2)
   ) dut (
      .clk         (clk),
      .clr         (clr),
      .tick_en     (tick_en),
      .ped_req     (ped_req),
      .night       (night),
      .lights      (lights),
      .walk        (walk),
      .ped_pending (ped_pending)
   );

   always #5 clk = ~clk;

   // Monitor: after each active edge the DUT presents one Moore output word.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (lights !== e.l || walk !== e.w || ped_pending !== e.p) begin
               mismatched++;
               $display("FAIL %s: got lights=%b walk=%b pend=%b, want lights=%b walk=%b pend=%b",
                        e.tag, lights, walk, ped_pending, e.l, e.w, e.p);
            end
         end
      end
   end

   // n cycles with the given inputs; each cycle expects the given outputs
   // after the edge that samples those inputs.
   task automatic run(input int n, input logic c, input logic t, input logic p, input logic ng,
                      input logic [5:0] el, input logic ew, input logic ep, input string tag);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         clr     = c;
         tick_en = t;
         ped_req = p;
         night   = ng;
         e.l   = el;
         e.w   = ew;
         e.p   = ep;
         e.tag = tag;
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset(input string tag);
      run(1, 1'b1, 1'b1, 1'b0, 1'b0, EWG, 1'b0, 1'b0, tag);
   endtask

   initial begin
      // 1: reset then two full free-running periods
      do_reset("s1_reset");
      for (int k = 0; k < 2; k++) begin
         run((k == 0) ? 4 : 5, 0, 1, 0, 0, EWG, 0, 0, "s1_ewg");
         run(2, 0, 1, 0, 0, EWY, 0, 0, "s1_ewy");
         run(1, 0, 1, 0, 0, AR,  0, 0, "s1_ar1");
         run(5, 0, 1, 0, 0, NSG, 0, 0, "s1_nsg");
         run(2, 0, 1, 0, 0, NSY, 0, 0, "s1_nsy");
         run(1, 0, 1, 0, 0, AR,  0, 0, "s1_ar2");
      end
      run(1, 0, 1, 0, 0, EWG, 0, 0, "s1_wrap");

      // 2: one-cycle request during the 2nd EW_GREEN cycle
      do_reset("s2_reset");
      run(1, 0, 1, 0, 0, EWG, 0, 0, "s2_ewg");
      run(1, 0, 1, 1, 0, EWG, 0, 1, "s2_latch");
      run(2, 0, 1, 0, 0, EWG, 0, 1, "s2_ewg_pend");
      run(2, 0, 1, 0, 0, EWY, 0, 1, "s2_ewy");
      run(1, 0, 1, 0, 0, AR,  0, 1, "s2_ar1");
      run(3, 0, 1, 0, 0, AR,  1, 0, "s2_walk");
      run(5, 0, 1, 0, 0, NSG, 0, 0, "s2_nsg");
      run(2, 0, 1, 0, 0, NSY, 0, 0, "s2_nsy");
      run(1, 0, 1, 0, 0, AR,  0, 0, "s2_ar2");
      run(1, 0, 1, 0, 0, EWG, 0, 0, "s2_ewg2");

      // 3: request held across the WALK entry edge
      do_reset("s3_reset");
      run(4, 0, 1, 1, 0, EWG, 0, 1, "s3_ewg");
      run(2, 0, 1, 1, 0, EWY, 0, 1, "s3_ewy");
      run(1, 0, 1, 1, 0, AR,  0, 1, "s3_ar1");
      run(1, 0, 1, 1, 0, AR,  1, 1, "s3_walk_entry");
      run(2, 0, 1, 0, 0, AR,  1, 1, "s3_walk1");
      run(5, 0, 1, 0, 0, NSG, 0, 1, "s3_nsg");
      run(2, 0, 1, 0, 0, NSY, 0, 1, "s3_nsy");
      run(1, 0, 1, 0, 0, AR,  0, 1, "s3_ar2");
      run(3, 0, 1, 0, 0, AR,  1, 0, "s3_walk2");
      run(5, 0, 1, 0, 0, EWG, 0, 0, "s3_ewg_ret");
      run(1, 0, 1, 0, 0, EWY, 0, 0, "s3_ewy_ret");

      // 4: night requested during EW_GREEN, then released mid-flash
      do_reset("s4_reset");
      run(4, 0, 1, 0, 1, EWG, 0, 0, "s4_ewg");
      run(2, 0, 1, 0, 1, EWY, 0, 0, "s4_ewy");
      run(1, 0, 1, 0, 1, AR,  0, 0, "s4_ar1");
      run(2, 0, 1, 0, 1, FON, 0, 0, "s4_flash_on");
      run(2, 0, 1, 0, 1, DRK, 0, 0, "s4_flash_off");
      run(1, 0, 1, 0, 1, FON, 0, 0, "s4_flash_on2");
      run(1, 0, 1, 0, 0, AR,  0, 0, "s4_clear");
      run(5, 0, 1, 0, 0, EWG, 0, 0, "s4_ewg_ret");
      run(1, 0, 1, 0, 0, EWY, 0, 0, "s4_ewy_ret");

      // 5: tick_en low for 10 cycles after two NS_GREEN cycles
      do_reset("s5_reset");
      run(4, 0, 1, 0, 0, EWG, 0, 0, "s5_ewg");
      run(2, 0, 1, 0, 0, EWY, 0, 0, "s5_ewy");
      run(1, 0, 1, 0, 0, AR,  0, 0, "s5_ar1");
      run(2, 0, 1, 0, 0, NSG, 0, 0, "s5_nsg_pre");
      run(10, 0, 0, 0, 0, NSG, 0, 0, "s5_frozen");
      run(3, 0, 1, 0, 0, NSG, 0, 0, "s5_nsg_post");
      run(2, 0, 1, 0, 0, NSY, 0, 0, "s5_nsy");
      run(1, 0, 1, 0, 0, AR,  0, 0, "s5_ar2");

      // 6: clr during WALK with a request still pending
      do_reset("s6_reset");
      run(4, 0, 1, 1, 0, EWG, 0, 1, "s6_ewg");
      run(2, 0, 1, 1, 0, EWY, 0, 1, "s6_ewy");
      run(1, 0, 1, 1, 0, AR,  0, 1, "s6_ar1");
      run(1, 0, 1, 1, 0, AR,  1, 1, "s6_walk");
      run(1, 1, 1, 0, 0, EWG, 0, 0, "s6_clr");
      run(4, 0, 1, 0, 0, EWG, 0, 0, "s6_ewg_full");
      run(1, 0, 1, 0, 0, EWY, 0, 0, "s6_ewy");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
